// File: rtl/uart_tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_sched_pkg
// Shared constants and types for the UART transmit scheduler.
//   UART_SYS_CLK / UART_BPS  : system clock and line rate
//   UART_BIT_CYCLES          : clk cycles per UART bit
//   UART_FRAME_BITS          : 8N1 frame length (start + 8 data + stop)
//   UART_FRAME_CYCLES        : clk cycles per complete frame
//   sched_state_e            : scheduler FSM encoding
//   cnt_width()              : bits needed for a 0..n-1 counter or index
// -----------------------------------------------------------------------------
package uart_tx_sched_pkg;

    localparam int unsigned UART_SYS_CLK      = 50_000_000;
    localparam int unsigned UART_BPS          = 9600;
    localparam int unsigned UART_BIT_CYCLES   = UART_SYS_CLK / UART_BPS;
    localparam int unsigned UART_FRAME_BITS   = 10;
    localparam int unsigned UART_FRAME_CYCLES = UART_BIT_CYCLES * UART_FRAME_BITS;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStart = 3'd2,
        StWait  = 3'd3,
        StGap   = 3'd4
    } sched_state_e;

    // Width of a counter/index covering 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_sched_rr_arbiter
// Combinational round-robin pick: first set request searching upward from
// last_grant_i + 1 with wrap-around.
//   req_i        : request vector
//   last_grant_i : index granted most recently
//   grant_o      : selected index (0 when no request)
//   any_req_o    : at least one request is set
// -----------------------------------------------------------------------------
module uart_tx_sched_rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW    = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    last_grant_i,
    output logic [IdxW-1:0]    grant_o,
    output logic               any_req_o
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        grant_o = '0;
        // Walk from the farthest candidate to the nearest so the nearest
        // requester after last_grant_i is the one left in grant_o.
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            idx = (32'(last_grant_i) + k) % NUM_REQ;
            if (req_i[idx[IdxW-1:0]]) begin
                grant_o = idx[IdxW-1:0];
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Round-robin scheduler sharing one 8N1 UART transmitter among NUM_REQ byte
// producers. One start_tx pulse per accepted byte, waits for done_tx (with a
// timeout), then holds an idle gap before arbitrating again.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   req_valid_i    : per-requester byte valid, held until req_ready_o
//   req_data_i     : byte for requester i in bits [8i+7:8i]
//   req_ready_o    : one-hot, single-cycle accept strobe (registered)
//   start_tx_o     : one-cycle start pulse to the transmitter
//   data_tx_o      : byte to transmit, held until the next accepted byte
//   done_tx_i      : one-cycle frame-complete pulse from the transmitter
//   busy_o         : scheduler is not idle
//   grant_id_o     : current or last granted requester
//   timeout_err_o  : one-cycle pulse when done_tx never arrived
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ        = 4,
    parameter  int unsigned GAP_CYCLES     = 16,
    // Must exceed UART_FRAME_CYCLES for the real transmitter.
    parameter  int unsigned TIMEOUT_CYCLES = 60000,
    localparam int unsigned IdxW           = cnt_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 start_tx_o,
    output logic [7:0]           data_tx_o,
    input  logic                 done_tx_i,
    output logic                 busy_o,
    output logic [IdxW-1:0]      grant_id_o,
    output logic                 timeout_err_o
);

    localparam int unsigned ToW  = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned GapW = cnt_width(GAP_CYCLES);

    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);
    // Only meaningful when GAP_CYCLES > 0; the gap state is skipped otherwise.
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    localparam sched_state_e AfterWait = (GAP_CYCLES == 0) ? StIdle : StGap;

    sched_state_e         state_q;
    logic [IdxW-1:0]      last_grant_q;
    logic [IdxW-1:0]      grant_id_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic                 start_tx_q;
    logic [7:0]           data_tx_q;
    logic                 busy_q;
    logic                 timeout_err_q;
    logic [ToW-1:0]       to_cnt_q;
    logic [GapW-1:0]      gap_cnt_q;

    logic [IdxW-1:0]      arb_grant;
    logic                 arb_any;

    uart_tx_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .any_req_o    (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            last_grant_q  <= IdxW'(NUM_REQ - 1);
            grant_id_q    <= '0;
            req_ready_q   <= '0;
            start_tx_q    <= 1'b0;
            data_tx_q     <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            req_ready_q   <= '0;
            start_tx_q    <= 1'b0;
            timeout_err_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        grant_id_q   <= arb_grant;
                        last_grant_q <= arb_grant;
                        state_q      <= StLoad;
                        busy_q       <= 1'b1;
                    end
                end

                StLoad: begin
                    if (req_valid_i[grant_id_q]) begin
                        req_ready_q[grant_id_q] <= 1'b1;
                        data_tx_q               <= req_data_i[8*grant_id_q +: 8];
                        state_q                 <= StStart;
                    end else begin
                        // Producer withdrew; last_grant_q keeps the skipped
                        // index so the search moves on past it.
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end

                StStart: begin
                    start_tx_q <= 1'b1;
                    to_cnt_q   <= '0;
                    state_q    <= StWait;
                end

                StWait: begin
                    // done_tx has priority over a coincident timeout.
                    if (done_tx_i || (to_cnt_q == ToLast)) begin
                        timeout_err_q <= !done_tx_i;
                        gap_cnt_q     <= '0;
                        state_q       <= AfterWait;
                        busy_q        <= (AfterWait != StIdle);
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign start_tx_o    = start_tx_q;
    assign data_tx_o     = data_tx_q;
    assign busy_o        = busy_q;
    assign grant_id_o    = grant_id_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter (8N1, 50 MHz / 9600 bps, 10-bit frame) among NUM_REQ byte producers.
- Accepts bytes over per-requester valid/ready handshakes and issues exactly one start_tx pulse per byte.
- Waits for the transmitter's done_tx, enforces an inter-frame idle gap, then arbitrates again.
- Sits between on-chip producers (debug console, status reporter, etc.) and the transmitter.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- GAP_CYCLES, 16: idle clk cycles after done_tx before the next grant; 0 means no gap state.
- TIMEOUT_CYCLES, 60000: max clk cycles in WAIT for done_tx; must exceed 10 × (sys_clk / bps) = 52080.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid; must be held until the matching req_ready.
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot, single-cycle accept strobe.
- start_tx  out  1  one-cycle pulse to the transmitter.
- data_tx  out  8  byte to transmit; stable from the start_tx cycle until done_tx.
- done_tx  in  1  one-cycle frame-complete pulse from the transmitter.
- busy  out  1  high in any state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- timeout_err  out  1  one-cycle pulse when TIMEOUT_CYCLES expires in WAIT.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered. req_ready is the only handshake output and is also registered.
- IDLE
  - If |req_valid, compute g = first set bit searching from last_grant+1 with wrap-around.
  - Register g into grant_id and last_grant; go to LOAD. Otherwise stay.
- LOAD (1 cycle)
  - If req_valid[g]: req_ready[g]=1 this cycle, data_tx<=req_data[g], go to START.
  - If req_valid[g] has dropped (protocol violation): no ready, go to IDLE; last_grant is still updated.
- START (1 cycle): start_tx=1, clear the timeout counter, go to WAIT.
- WAIT
  - Count cycles; on done_tx, go to GAP (or to IDLE if GAP_CYCLES=0).
  - If the count reaches TIMEOUT_CYCLES-1 without done_tx: timeout_err=1 for one cycle, then same next state as done_tx.
  - If done_tx and timeout coincide, done_tx wins and no error is flagged.
- GAP: count GAP_CYCLES cycles, then IDLE. Requests arriving here wait; they are not lost.
- start_tx is never asserted outside START. This guarantees no restart mid-frame, since the transmitter would reload data and restart its frame on any start_tx.
- done_tx outside WAIT is ignored.
- Latency: valid seen in IDLE at cycle N → req_ready at N+1 → start_tx at N+2.
- Back-to-back throughput: one frame + GAP_CYCLES + 3 cycles per byte.
- Fairness: a continuously-valid requester waits at most NUM_REQ-1 frames.
- Single requester: it is re-granted every turn.
- data_tx holds its value after a frame until the next LOAD.
- Async reset mid-frame returns the block to IDLE immediately. The transmitter shares rst_n and resets with it.

Decomposition:
- Shared package/header uart_pkg: UART_SYS_CLK=50_000_000, UART_BPS=9600, UART_BIT_CYCLES, UART_FRAME_BITS=10, and the state encodings (IDLE, LOAD, START, WAIT, GAP; 3-bit).
- One sub-module: rr_arbiter (parameterised NUM_REQ), combinational.
  - Inputs: request vector, last_grant.
  - Outputs: grant index and any_req.
- The FSM, counters and output registers live in uart_tx_sched.

Test Plan:
- Single byte: req_valid[2]=1, data 0xA5 → req_ready[2] 1 cycle later, start_tx next cycle with data_tx=0xA5, grant_id=2; with a real tx attached, line shows 0, 1,0,1,0,0,1,0,1, 1; busy drops GAP_CYCLES after done_tx.
- Round-robin: all four valid continuously with bytes 0x10/0x21/0x32/0x43 → serviced in order 0,1,2,3,0; exactly one start_tx per frame; the gap between a done_tx and the next start_tx is GAP_CYCLES+3 cycles.
- Collision: requester 1 asserts during WAIT of requester 3 → served after GAP, before requester 3 is served again; start_tx never high while busy in WAIT.
- Timeout: stub transmitter that never returns done_tx → timeout_err pulse exactly TIMEOUT_CYCLES cycles after START; block returns to IDLE after GAP.
- Withdrawn request: req_valid[0] dropped in the LOAD cycle → no req_ready, no start_tx, back to IDLE; next arbitration starts at requester 1.
- Reset mid-frame: rst_n low 3 cycles in the middle of WAIT → all outputs 0 asynchronously, state IDLE; after release, requester 0 has priority.
